// File: rtl/sa_clkgate_ctrl_if.sv
// Control/status bundle between a gated domain's producer and its clock-gate controller.
// Pure wiring, no latency; no backpressure, all signals are level-sampled every cycle.
// master drives activity/clear and observes the enable; slave is the controller.
interface sa_clkgate_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             busy_i;
    logic             req_i;
    logic             force_on_i;
    logic             clr_cnt_i;
    logic             clk_en_o;
    logic             ready_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] wake_cnt_o;

    modport master (
        output busy_i, req_i, force_on_i, clr_cnt_i,
        input  clk_en_o, ready_o, state_o, wake_cnt_o
    );

    modport slave (
        input  busy_i, req_i, force_on_i, clr_cnt_i,
        output clk_en_o, ready_o, state_o, wake_cnt_o
    );
endinterface

// File: rtl/sa_clkgate_ctrl.sv
// Idle-hysteresis clock-gate controller: warm-up before ready, cool-down before gating off.
// Enable rises on the edge sampling activity; ready follows WAKE_CYCLES edges later.
// No backpressure: activity is sampled every edge, and activity during warm-up is ignored.
module sa_clkgate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    sa_clkgate_ctrl_if.slave    bus
);
    localparam int MAX_LOAD = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int TW       = $clog2(MAX_LOAD + 1);
    localparam logic [TW-1:0] WAKE_LOAD = TW'(WAKE_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_LOAD = TW'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_COOL = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             clk_en_q, clk_en_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic             act;
    logic             wake_evt;

    always_comb begin
        act        = bus.busy_i | bus.req_i | bus.force_on_i;
        state_d    = state_q;
        cnt_d      = cnt_q;
        wake_evt   = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (act) begin
                    state_d  = ST_WAKE;
                    cnt_d    = WAKE_LOAD;
                    wake_evt = 1'b1;
                end
            end
            ST_WAKE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - TW'(1);
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (!act) begin
                    state_d = ST_COOL;
                    cnt_d   = IDLE_LOAD;
                end
            end
            // Renewed activity beats the counter and skips the warm-up.
            ST_COOL: begin
                if (act) begin
                    state_d = ST_ON;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - TW'(1);
                end else begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        // Registered from next-state so the AND-cell enable never glitches.
        clk_en_d = (state_d != ST_OFF);
        ready_d  = (state_d == ST_ON) || (state_d == ST_COOL);

        wake_cnt_d = wake_cnt_q;
        if (bus.clr_cnt_i) begin
            wake_cnt_d = '0;
        end else if (wake_evt && (wake_cnt_q != '1)) begin
            wake_cnt_d = wake_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            clk_en_q   <= 1'b0;
            ready_q    <= 1'b0;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_en_q   <= clk_en_d;
            ready_q    <= ready_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    assign bus.clk_en_o   = clk_en_q;
    assign bus.ready_o    = ready_q;
    assign bus.state_o    = state_q;
    assign bus.wake_cnt_o = wake_cnt_q;
endmodule

// File: doc/sa_clkgate_ctrl.md
# sa_clkgate_ctrl

Idle-hysteresis clock-gate controller for one gated SA cell-library clock domain. It watches activity and wake-request inputs and produces a registered enable, `clk_en_o`. That enable drives the enable input of the downstream two-input AND cell (`Z = A1 & A2`) that qualifies the domain's gated clock or valid path. The block applies a warm-up delay before reporting the domain ready and a cool-down delay before gating off. It also keeps a saturating count of wake events for performance monitoring.

## Interface
- IDLE_CYCLES, 16, consecutive inactive cycles spent in COOL before gating off; legal range 1..255
- WAKE_CYCLES, 2, cycles spent in WAKE before `ready_o` asserts; legal range 1..255
- CNT_W, 16, width of the wake-event counter
- clk  input  1  single clock; every flop is on its rising edge
- rst  input  1  reset, synchronous and active-high; one clock, no asynchronous reset path
- busy_i  input  1  domain activity; counts as activity
- req_i  input  1  wake request from the producer; counts as activity
- force_on_i  input  1  override that counts as activity (debug or test)
- clr_cnt_i  input  1  synchronous clear of `wake_cnt_o`
- clk_en_o  output  1  registered gate enable, driven to the AND cell enable input
- ready_o  output  1  registered; gated domain is warmed up and usable
- state_o  output  2  current state: OFF=0, WAKE=1, ON=2, COOL=3
- wake_cnt_o  output  CNT_W  saturating count of OFF->WAKE transitions

## Operation
- Activity is defined as `act = busy_i | req_i | force_on_i`, sampled on every rising edge.
- There is one down-counter `cnt` of width clog2(max(IDLE_CYCLES, WAKE_CYCLES)+1).
- State machine:
  - OFF: when `act`=1, go to WAKE and load `cnt=WAKE_CYCLES-1`; otherwise stay in OFF.
  - WAKE: `act` is ignored. While `cnt`!=0, decrement `cnt`. When `cnt`==0, go to ON.
  - ON: when `act`=1, stay in ON. When `act`=0, go to COOL and load `cnt=IDLE_CYCLES-1`.
  - COOL: when `act`=1, return to ON; this takes priority over the counter and does not re-enter WAKE. When `act`=0 and `cnt`!=0, decrement `cnt`. When `act`=0 and `cnt`==0, go to OFF.
- Outputs are flops loaded from the next-state value, so they never glitch:
  - `clk_en_o` = (next state != OFF)
  - `ready_o` = (next state is ON or COOL)
  - `state_o` = current state register
- `wake_cnt_o` increments by 1 on each OFF->WAKE transition.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - `clr_cnt_i` clears it to 0. When `clr_cnt_i` and an increment occur in the same cycle, the clear wins and the result is 0.
- Reset values: state=OFF, cnt=0, `clk_en_o`=0, `ready_o`=0, `state_o`=0, `wake_cnt_o`=0.
- Reset mid-operation, including mid-WAKE or mid-COOL, returns to OFF on the next edge and the enable drops. No clock-off handshake is performed.

## Timing
- Wake latency: `act` is sampled high at edge t while in OFF.
  - `clk_en_o`=1 from edge t.
  - `ready_o`=1 from edge t+WAKE_CYCLES.
- Gate-off latency: the last `act`=1 is sampled at edge u while in ON.
  - The state is COOL from edge u+1.
  - `clk_en_o`=0 and state=OFF from edge u+1+IDLE_CYCLES.
- A single-cycle `act` pulse during COOL restarts the full hysteresis: the state returns to ON, and the next inactive cycle reloads `cnt`.
- `act` falling during WAKE does not abort the wake. The sequence passes through ON, then COOL, then OFF.
- `act`=1 on the same edge that COOL reaches `cnt`==0 keeps the domain on (state goes to ON).
- `act`=1 on the cycle right after OFF is re-entered starts a new wake, and `wake_cnt_o` increments again.
- `ready_o`=1 always implies `clk_en_o`=1. No cycle may show `ready_o`=1 with `clk_en_o`=0.
- There are no combinational paths from inputs to outputs.

## Test plan
Directed scenarios, run with IDLE_CYCLES=4, WAKE_CYCLES=2, CNT_W=4:
- Reset: hold `rst`=1 for 2 cycles with all inputs high -> all outputs 0 and `state_o`=0. After release with `act` high, `clk_en_o`=1 at the first edge.
- Basic wake: `req_i` pulse for 1 cycle sampled at edge t -> `clk_en_o`=1 from edge t; state WAKE at edges t, t+1; `ready_o`=1 and state ON at edge t+2; state COOL at edge t+3; `clk_en_o`=0 at edge t+7; `wake_cnt_o`=1.
- Hysteresis restart: while ON, hold `busy_i` low for 3 cycles, pulse it for 1 cycle, then hold it low -> `clk_en_o` never drops during the pulse window; OFF is reached 5 edges after the pulse; `wake_cnt_o` is unchanged.
- Reset mid-operation: assert `rst` during WAKE and again during COOL -> state=OFF, `clk_en_o`=0, `ready_o`=0 on the next edge; `wake_cnt_o`=0.
- Saturation and clear: perform 17 wake/off cycles -> `wake_cnt_o` stops at 15. Assert `clr_cnt_i` on the same cycle as an OFF->WAKE transition -> `wake_cnt_o`=0.
- Random stimulus: drive random `busy_i`/`req_i`/`force_on_i` for 10k cycles -> a checker confirms `ready_o` implies `clk_en_o`, that each WAKE lasts exactly 2 cycles, and that there are never fewer than 5 consecutive inactive samples between leaving ON and OFF.
